// File: rtl/hybrid_control_theta_dt_pkg.sv
// Shared types, defaults and integer-degree trigonometry for the half-plane hybrid controller.
// Pure declarations; no state, no timing.
package hybrid_control_theta_dt_pkg;

    localparam int DEF_DATA_W    = 14;
    localparam int DEF_MU_Z1     = 86;
    localparam int DEF_MU_Z2     = 90;
    localparam int DEF_MU_VG     = 312000;
    localparam int DEF_DELAY     = 400;
    localparam int DEF_DEAD_TIME = 10;
    localparam int DEF_CNT_W     = 12;

    localparam int S_W      = 64;
    localparam int TRIG_ONE = 16384;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEAD = 2'd1,
        ST_COND = 2'd2
    } state_t;

    localparam logic [3:0] GATE_OFF  = 4'b0000;
    localparam logic [3:0] GATE_SIG1 = 4'b1001;
    localparam logic [3:0] GATE_SIG0 = 4'b0110;

    typedef struct packed {
        logic signed [31:0] sin_v;
        logic signed [31:0] cos_v;
    } trig_t;

    function automatic logic [3:0] gate_pattern(input logic sigma);
        return sigma ? GATE_SIG1 : GATE_SIG0;
    endfunction

    // Bhaskara sine over 0..180 degrees, scaled so 90 degrees gives exactly TRIG_ONE.
    function automatic logic signed [31:0] sin_half(input logic [8:0] x);
        logic [31:0] p;
        logic [31:0] num;
        logic [31:0] den;
        p   = 32'(x) * (32'd180 - 32'(x));
        num = p << 16;
        den = 32'd40500 - p;
        return $signed(num / den);
    endfunction

    function automatic trig_t trigonometry_deg(input logic signed [31:0] theta_deg);
        trig_t              res;
        logic signed [31:0] r;
        logic [8:0]         t;
        logic [8:0]         tc;
        r = theta_deg % 32'sd360;
        if (r < 0) begin
            r = r + 32'sd360;
        end
        t  = r[8:0];
        tc = (t >= 9'd270) ? (t - 9'd270) : (t + 9'd90);
        res.sin_v = (t  < 9'd180) ? sin_half(t)  : -sin_half(t  - 9'd180);
        res.cos_v = (tc < 9'd180) ? sin_half(tc) : -sin_half(tc - 9'd180);
        return res;
    endfunction

endpackage

// File: rtl/hybrid_control_theta_dt_if.sv
// Sample/angle inputs and gate/status outputs of the hybrid controller.
// Plain wires; the controller never stalls its sample stream.
interface hybrid_control_theta_dt_if
    import hybrid_control_theta_dt_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic                     i_enable;
    logic signed [DATA_W-1:0] i_vC;
    logic signed [DATA_W-1:0] i_iC;
    logic signed [31:0]       i_theta;
    logic [3:0]               o_MOSFET;
    logic                     o_sigma;
    logic                     o_switch;
    logic [15:0]              o_debug;

    modport master (
        output i_enable, i_vC, i_iC, i_theta,
        input  o_MOSFET, o_sigma, o_switch, o_debug
    );

    modport slave (
        input  i_enable, i_vC, i_iC, i_theta,
        output o_MOSFET, o_sigma, o_switch, o_debug
    );
endinterface

// File: rtl/hybrid_control_theta_dt_surface.sv
// Three-stage switching-surface pipeline: z1/z2/sin/cos, products, S; emits sign(S) and fill-valid.
// Latency 3 cycles from sample to S; free-running, no backpressure.
module hybrid_control_theta_dt_surface
    import hybrid_control_theta_dt_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int MU_Z1  = DEF_MU_Z1,
    parameter int MU_Z2  = DEF_MU_Z2,
    parameter int MU_VG  = DEF_MU_VG
) (
    input  logic                     i_clock,
    input  logic                     i_RESET,
    input  logic signed [DATA_W-1:0] vc,
    input  logic signed [DATA_W-1:0] ic,
    input  logic signed [31:0]       theta,
    input  logic                     sigma,
    output logic                     s_sign,
    output logic                     s_vld
);
    logic signed [31:0]    vc_ext;
    logic signed [31:0]    ic_ext;
    trig_t                 trig;

    logic signed [31:0]    z1_d,  z1_q;
    logic signed [31:0]    z2_d,  z2_q;
    logic signed [31:0]    sin_d, sin_q;
    logic signed [31:0]    cos_d, cos_q;
    logic signed [S_W-1:0] prod1_d, prod1_q;
    logic signed [S_W-1:0] prod2_d, prod2_q;
    logic signed [S_W-1:0] s_d, s_q;
    logic [2:0]            vld_d, vld_q;

    always_comb begin
        vc_ext = {{(32-DATA_W){vc[DATA_W-1]}}, vc};
        ic_ext = {{(32-DATA_W){ic[DATA_W-1]}}, ic};
        trig   = trigonometry_deg(theta);

        // sigma_not is +1 while sigma=0 and -1 while sigma=1.
        z1_d  = MU_Z1 * vc_ext + (sigma ? -32'(MU_VG) : 32'(MU_VG));
        z2_d  = MU_Z2 * ic_ext;
        sin_d = trig.sin_v;
        cos_d = trig.cos_v;

        prod1_d = $signed({{32{z1_q[31]}}, z1_q}) * $signed({{32{sin_q[31]}}, sin_q});
        prod2_d = $signed({{32{z2_q[31]}}, z2_q}) * $signed({{32{cos_q[31]}}, cos_q});
        s_d     = prod1_q + prod2_q;
        vld_d   = {vld_q[1:0], 1'b1};
    end

    always_ff @(posedge i_clock) begin
        if (i_RESET) begin
            z1_q    <= '0;
            z2_q    <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            prod1_q <= '0;
            prod2_q <= '0;
            s_q     <= '0;
            vld_q   <= '0;
        end else begin
            z1_q    <= z1_d;
            z2_q    <= z2_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            prod1_q <= prod1_d;
            prod2_q <= prod2_d;
            s_q     <= s_d;
            vld_q   <= vld_d;
        end
    end

    // S==0 reads as non-negative, requesting sigma=0.
    assign s_sign = s_q[S_W-1];
    assign s_vld  = vld_q[2];

endmodule

// File: rtl/hybrid_control_theta_dt.sv
// Half-plane hybrid controller: surface pipeline, dwell-inhibited sigma FSM, dead-time gate mapping.
// Toggle lands 4 cycles after the deciding sample; all outputs registered, no backpressure.
module hybrid_control_theta_dt
    import hybrid_control_theta_dt_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MU_Z1     = DEF_MU_Z1,
    parameter int MU_Z2     = DEF_MU_Z2,
    parameter int MU_VG     = DEF_MU_VG,
    parameter int DELAY     = DEF_DELAY,
    parameter int DEAD_TIME = DEF_DEAD_TIME,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                        i_clock,
    input  logic                        i_RESET,
    hybrid_control_theta_dt_if.slave    bus
);
    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0] DEAD_C  = CNT_W'(DEAD_TIME);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state_d,  state_q;
    logic             sigma_d,  sigma_q;
    logic             switch_d, switch_q;
    logic [3:0]       mos_d,    mos_q;
    logic [CNT_W-1:0] dwell_d,  dwell_q;
    logic             s_sign;
    logic             s_vld;
    logic             jump_en;

    hybrid_control_theta_dt_surface #(
        .DATA_W (DATA_W),
        .MU_Z1  (MU_Z1),
        .MU_Z2  (MU_Z2),
        .MU_VG  (MU_VG)
    ) u_surface (
        .i_clock (i_clock),
        .i_RESET (i_RESET),
        .vc      (bus.i_vC),
        .ic      (bus.i_iC),
        .theta   (bus.i_theta),
        .sigma   (sigma_q),
        .s_sign  (s_sign),
        .s_vld   (s_vld)
    );

    assign jump_en = (state_q == ST_COND) && (dwell_q == DELAY_C);

    always_comb begin
        state_d  = state_q;
        sigma_d  = sigma_q;
        switch_d = 1'b0;
        mos_d    = mos_q;
        dwell_d  = dwell_q;

        if (!bus.i_enable) begin
            state_d = ST_IDLE;
            mos_d   = GATE_OFF;
            dwell_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_DEAD;
                    sigma_d = 1'b1;
                    dwell_d = ONE_C;
                    mos_d   = GATE_OFF;
                end
                ST_DEAD: begin
                    mos_d   = GATE_OFF;
                    dwell_d = dwell_q + ONE_C;
                    if (dwell_q == DEAD_C) begin
                        state_d = ST_COND;
                        mos_d   = gate_pattern(sigma_q);
                    end
                end
                ST_COND: begin
                    // Requests arriving before the dwell expires are simply dropped.
                    if (jump_en && s_vld && (s_sign != sigma_q)) begin
                        state_d  = ST_DEAD;
                        sigma_d  = ~sigma_q;
                        switch_d = 1'b1;
                        dwell_d  = ONE_C;
                        mos_d    = GATE_OFF;
                    end else begin
                        mos_d = gate_pattern(sigma_q);
                        if (dwell_q != DELAY_C) begin
                            dwell_d = dwell_q + ONE_C;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    mos_d   = GATE_OFF;
                    dwell_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_RESET) begin
            state_q  <= ST_IDLE;
            sigma_q  <= 1'b1;
            switch_q <= 1'b0;
            mos_q    <= GATE_OFF;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            sigma_q  <= sigma_d;
            switch_q <= switch_d;
            mos_q    <= mos_d;
            dwell_q  <= dwell_d;
        end
    end

    assign bus.o_MOSFET = mos_q;
    assign bus.o_sigma  = sigma_q;
    assign bus.o_switch = switch_q;
    assign bus.o_debug  = {state_q, s_sign, jump_en, 12'(dwell_q)};

endmodule

// File: tb/tb_hybrid_control_theta_dt.sv
// Directed + randomized bench for the hybrid controller with a toggle scoreboard and gate-safety monitor.
module tb_hybrid_control_theta_dt;
    localparam int DW        = 14;
    localparam int DELAY     = 400;
    localparam int DEAD_TIME = 10;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hybrid_control_theta_dt_if #(.DATA_W(DW)) bus ();

    hybrid_control_theta_dt dut (
        .i_clock (clk),
        .i_RESET (rst),
        .bus     (bus)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   exp_cyc[$];
    logic exp_sig[$];
    bit   model_on  = 1'b0;
    bit   rnd_phase = 1'b0;
    int   t_last    = 0;
    logic sig_m     = 1'b1;
    int   viol      = 0;
    int   last_sw   = -1;
    logic prev_jump = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // With theta=0, S follows the sign of iC; a request is honoured at the first edge
    // at least DELAY cycles after the previous toggle/startup, four edges after it is driven.
    task automatic drive(input int ic);
        logic req;
        bus.i_iC = DW'(ic);
        req = (ic < 0);
        if (model_on && ((cyc + 4 - t_last) >= DELAY) && (req != sig_m)) begin
            exp_cyc.push_back(cyc + 4);
            exp_sig.push_back(req);
            t_last = cyc + 4;
            sig_m  = req;
        end
        tick();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin : monitor
        logic [3:0] prev_m;
        logic [3:0] m;
        int         zrun;
        prev_m = 4'b0;
        zrun   = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_m = 4'b0;
                zrun   = 0;
            end else begin
                m = bus.o_MOSFET;
                if (((m[3] & m[2]) | (m[1] & m[0])) !== 1'b0) viol++;
                if (m === 4'b0) begin
                    zrun++;
                end else begin
                    if ((m !== prev_m) && ((prev_m !== 4'b0) || (zrun < DEAD_TIME))) viol++;
                    zrun = 0;
                end
                prev_m = m;
                if (bus.o_switch === 1'b1) begin
                    if (last_sw >= 0) chk("toggle_spacing", 64'((cyc - last_sw) >= DELAY), 1);
                    chk("switch_after_jump_en", prev_jump, 1);
                    last_sw = cyc;
                    if (!rnd_phase) begin
                        if (exp_cyc.size() == 0) begin
                            chk("unexpected_switch", bus.o_switch, 0);
                        end else begin
                            chk("switch_cycle", cyc, exp_cyc.pop_front());
                            chk("switch_sigma", bus.o_sigma, exp_sig.pop_front());
                        end
                    end
                end else if (!rnd_phase && (exp_cyc.size() > 0) && (exp_cyc[0] < cyc)) begin
                    chk("missed_switch", cyc, exp_cyc.pop_front());
                    void'(exp_sig.pop_front());
                end
                prev_jump = bus.o_debug[12];
            end
        end
    end

    int tab_vc[7]  = '{8191, -8192, 8191, 8191,   0,    0, 0};
    int tab_ic[7]  = '{   0,     0,    0,    0, 100, -100, 0};
    int tab_th[7]  = '{  90,    90, -270,  270, 180,    0, 0};
    int tab_sg[7]  = '{   0,     1,    0,    1,   1,    1, 0};

    initial begin : main
        int bad;
        int k;
        int prev_sign;
        int seg;
        int ic_r;

        rst          = 1'b1;
        bus.i_enable = 1'b0;
        bus.i_vC     = '0;
        bus.i_iC     = -14'sd100;
        bus.i_theta  = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_sigma",  bus.o_sigma, 1);
        chk("rst_mos",    bus.o_MOSFET, 4'b0000);
        chk("rst_switch", bus.o_switch, 0);
        chk("rst_state",  bus.o_debug[15:14], 0);
        chk("rst_dwell",  bus.o_debug[11:0], 0);
        drive(-100);

        // Startup
        bus.i_enable = 1'b1;
        tick();
        model_on = 1'b1;
        t_last   = cyc;
        sig_m    = 1'b1;
        chk("start_state", bus.o_debug[15:14], 1);
        chk("start_dwell", bus.o_debug[11:0], 1);
        chk("start_sigma", bus.o_sigma, 1);
        bad = 0;
        for (int i = 1; i <= 9; i++) begin
            drive(-100);
            if (bus.o_MOSFET !== 4'b0000) bad++;
        end
        chk("start_dead_off", bad, 0);
        drive(-100);
        chk("start_pattern", bus.o_MOSFET, 4'b1001);
        chk("start_cond", bus.o_debug[15:14], 2);

        k = 0;
        while ((bus.o_debug[12] !== 1'b1) && (k < 500)) begin
            drive(-100);
            k++;
        end
        chk("jump_en_cycle", cyc - t_last, DELAY - 1);
        chk("dwell_at_delay", bus.o_debug[11:0], DELAY);
        drive(-100);
        chk("dwell_saturates", bus.o_debug[11:0], DELAY);
        chk("no_toggle_same_sign", bus.o_sigma, 1);

        // Toggle four edges after iC changes sign
        drive(100);
        drive(100);
        drive(100);
        chk("sigma_before_k4", bus.o_sigma, 1);
        drive(100);
        chk("sigma_at_k4", bus.o_sigma, 0);
        chk("switch_at_k4", bus.o_switch, 1);
        chk("mos_at_k4", bus.o_MOSFET, 4'b0000);
        bad = 0;
        for (int i = 1; i <= 9; i++) begin
            drive(100);
            if (i == 1) chk("switch_one_cycle", bus.o_switch, 0);
            if (bus.o_MOSFET !== 4'b0000) bad++;
        end
        chk("toggle_dead_off", bad, 0);
        drive(100);
        chk("toggle_pattern", bus.o_MOSFET, 4'b0110);

        // Inhibit: sign flips every 50 cycles
        for (int n = 0; n < 1200; n++) begin
            drive((((n / 50) % 2) == 0) ? -100 : 100);
        end

        // Disable mid-DEAD
        k = 0;
        while ((bus.o_switch !== 1'b1) && (k < 1000)) begin
            drive((bus.o_sigma === 1'b1) ? 100 : -100);
            k++;
        end
        chk("got_switch", bus.o_switch, 1);
        for (int i = 0; i < 4; i++) drive(-100);
        chk("dead_dwell5", bus.o_debug[11:0], 5);
        chk("dead_state", bus.o_debug[15:14], 1);
        bus.i_enable = 1'b0;
        model_on     = 1'b0;
        drive(-100);
        chk("dis_mos", bus.o_MOSFET, 4'b0000);
        chk("dis_state", bus.o_debug[15:14], 0);
        chk("dis_sigma_held", bus.o_sigma, sig_m);
        chk("dis_dwell", bus.o_debug[11:0], 0);
        drive(-100);
        bus.i_enable = 1'b1;
        drive(-100);
        model_on = 1'b1;
        t_last   = cyc;
        sig_m    = 1'b1;
        chk("reen_sigma", bus.o_sigma, 1);
        chk("reen_state", bus.o_debug[15:14], 1);
        chk("reen_dwell", bus.o_debug[11:0], 1);
        bad = 0;
        for (int i = 1; i <= 9; i++) begin
            drive(-100);
            if (bus.o_MOSFET !== 4'b0000) bad++;
        end
        chk("reen_dead_off", bad, 0);
        drive(-100);
        chk("reen_pattern", bus.o_MOSFET, 4'b1001);
        chk("queue_empty", exp_cyc.size(), 0);

        // Surface sign, latency and wide-range samples
        model_on  = 1'b0;
        rnd_phase = 1'b1;
        prev_sign = 1;
        for (int e = 0; e < 7; e++) begin
            bus.i_vC    = DW'(tab_vc[e]);
            bus.i_iC    = DW'(tab_ic[e]);
            bus.i_theta = tab_th[e];
            tick();
            tick();
            chk($sformatf("s_sign_hold_%0d", e), bus.o_debug[13], prev_sign);
            tick();
            chk($sformatf("s_sign_%0d", e), bus.o_debug[13], tab_sg[e]);
            prev_sign = tab_sg[e];
        end

        // Random samples held for a while each
        for (seg = 0; seg < 60; seg++) begin
            ic_r        = int'($urandom_range(0, 16383)) - 8192;
            bus.i_vC    = DW'(int'($urandom_range(0, 16383)) - 8192);
            bus.i_iC    = DW'(ic_r);
            bus.i_theta = int'($urandom_range(0, 1440)) - 720;
            k = int'($urandom_range(10, 80));
            for (int i = 0; i < k; i++) tick();
        end

        chk("gate_safety", viol, 0);
        chk("queue_drained", exp_cyc.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
